// File: rtl/fp_adder_pipe.sv
// -----------------------------------------------------------------------------
// fp_adder_pipe
//
// Four-stage pipelined floating-point adder/subtractor. Operand format is
// sign, unsigned (unbiased) exponent and a fraction with an explicit leading
// bit at the MSB. Truncating alignment, no rounding. Overflow saturates and
// flags ovf. A result that cannot be normalised is flushed to zero and flags
// unf.
//
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous, active-high reset
//   in_valid  : operand pair valid
//   in_ready  : pipeline accepts an operand pair this cycle
//   op        : 0 = add, 1 = subtract (operand 1 - operand 2)
//   sign1/exp1/frac1 : operand 1
//   sign2/exp2/frac2 : operand 2
//   out_valid : result valid
//   out_ready : consumer accepts the result
//   sign_out/exp_out/frac_out : result
//   ovf       : exponent overflow, result saturated
//   unf       : result too small to normalise, flushed to zero
//
// Handshake: an input transfer occurs on a rising edge where in_valid and
// in_ready are both 1; an output transfer occurs where out_valid and
// out_ready are both 1. The pipeline stalls when out_valid && !out_ready:
// every stage register holds, so the outputs stay stable until taken, and
// in_ready (= !stall) drops combinationally. Bubbles travel through the
// pipeline and are never squeezed out.
// -----------------------------------------------------------------------------
module fp_adder_pipe #(
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op,
  input  logic              sign1,
  input  logic [EXP_W-1:0]  exp1,
  input  logic [FRAC_W-1:0] frac1,
  input  logic              sign2,
  input  logic [EXP_W-1:0]  exp2,
  input  logic [FRAC_W-1:0] frac2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic [FRAC_W-1:0] frac_out,
  output logic              ovf,
  output logic              unf
);

  // lead0 spans 0..FRAC_W-1; FRAC_W >= 4 keeps this at least 2 bits.
  localparam int LZ_W = $clog2(FRAC_W);
  localparam logic [EXP_W-1:0] EXP_MAX  = '1;
  localparam logic [31:0]      FRAC_W_U = 32'(FRAC_W);

  logic w_stall;

  // ---------------------------------------------------------------------------
  // Stage 1: sort operands into big/small
  // ---------------------------------------------------------------------------
  logic w_sign2_eff;
  logic w_op1_big;

  logic              r_s1_valid;
  logic              r_s1_signb, r_s1_signs;
  logic [EXP_W-1:0]  r_s1_expb,  r_s1_exps;
  logic [FRAC_W-1:0] r_s1_fracb, r_s1_fracs;

  assign w_sign2_eff = sign2 ^ op;
  // Strict compare: on a tie operand 2 becomes the big operand.
  assign w_op1_big   = {exp1, frac1} > {exp2, frac2};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_signb <= 1'b0;
      r_s1_signs <= 1'b0;
      r_s1_expb  <= '0;
      r_s1_exps  <= '0;
      r_s1_fracb <= '0;
      r_s1_fracs <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= in_valid;
      if (w_op1_big) begin
        r_s1_signb <= sign1;
        r_s1_expb  <= exp1;
        r_s1_fracb <= frac1;
        r_s1_signs <= w_sign2_eff;
        r_s1_exps  <= exp2;
        r_s1_fracs <= frac2;
      end else begin
        r_s1_signb <= w_sign2_eff;
        r_s1_expb  <= exp2;
        r_s1_fracb <= frac2;
        r_s1_signs <= sign1;
        r_s1_exps  <= exp1;
        r_s1_fracs <= frac1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: align the small fraction
  // ---------------------------------------------------------------------------
  logic [EXP_W-1:0]  w_diff;
  logic [FRAC_W-1:0] w_aligned;

  logic              r_s2_valid;
  logic              r_s2_signb;
  logic              r_s2_same;
  logic [EXP_W-1:0]  r_s2_expb;
  logic [FRAC_W-1:0] r_s2_fracb;
  logic [FRAC_W-1:0] r_s2_aligned;

  // The sort guarantees expb >= exps, so the difference never wraps.
  assign w_diff    = r_s1_expb - r_s1_exps;
  assign w_aligned = (32'(w_diff) >= FRAC_W_U) ? '0 : (r_s1_fracs >> w_diff);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid   <= 1'b0;
      r_s2_signb   <= 1'b0;
      r_s2_same    <= 1'b0;
      r_s2_expb    <= '0;
      r_s2_fracb   <= '0;
      r_s2_aligned <= '0;
    end else if (!w_stall) begin
      r_s2_valid   <= r_s1_valid;
      r_s2_signb   <= r_s1_signb;
      r_s2_same    <= (r_s1_signb == r_s1_signs);
      r_s2_expb    <= r_s1_expb;
      r_s2_fracb   <= r_s1_fracb;
      r_s2_aligned <= w_aligned;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: magnitude add or subtract
  // ---------------------------------------------------------------------------
  logic [FRAC_W:0] w_sum;

  logic             r_s3_valid;
  logic             r_s3_sign;
  logic [EXP_W-1:0] r_s3_expb;
  logic [FRAC_W:0]  r_s3_sum;

  // big >= aligned small, so the difference is never negative.
  assign w_sum = r_s2_same ? ({1'b0, r_s2_fracb} + {1'b0, r_s2_aligned})
                           : ({1'b0, r_s2_fracb} - {1'b0, r_s2_aligned});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s3_valid <= 1'b0;
      r_s3_sign  <= 1'b0;
      r_s3_expb  <= '0;
      r_s3_sum   <= '0;
    end else if (!w_stall) begin
      r_s3_valid <= r_s2_valid;
      r_s3_sign  <= r_s2_signb;
      r_s3_expb  <= r_s2_expb;
      r_s3_sum   <= w_sum;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 4: normalise, saturate or flush; drives the output registers
  // ---------------------------------------------------------------------------
  logic [LZ_W-1:0]   w_lead0;
  logic              w_n_sign;
  logic [EXP_W-1:0]  w_n_exp;
  logic [FRAC_W-1:0] w_n_frac;
  logic              w_n_ovf;
  logic              w_n_unf;

  // Ascending scan: the highest set bit is written last and wins.
  always_comb begin
    w_lead0 = '0;
    for (int i = 0; i < FRAC_W; i++) begin
      if (r_s3_sum[i]) w_lead0 = LZ_W'(FRAC_W - 1 - i);
    end
  end

  always_comb begin
    w_n_sign = r_s3_sign;
    w_n_exp  = r_s3_expb;
    w_n_frac = r_s3_sum[FRAC_W-1:0];
    w_n_ovf  = 1'b0;
    w_n_unf  = 1'b0;
    if (r_s3_sum == '0) begin
      // Exact cancellation gives a clean positive zero.
      w_n_sign = 1'b0;
      w_n_exp  = '0;
      w_n_frac = '0;
    end else if (r_s3_sum[FRAC_W]) begin
      if (r_s3_expb != EXP_MAX) begin
        w_n_exp  = r_s3_expb + EXP_W'(1);
        w_n_frac = r_s3_sum[FRAC_W:1];
      end else begin
        w_n_exp  = '1;
        w_n_frac = '1;
        w_n_ovf  = 1'b1;
      end
    end else if (32'(w_lead0) > 32'(r_s3_expb)) begin
      w_n_sign = 1'b0;
      w_n_exp  = '0;
      w_n_frac = '0;
      w_n_unf  = 1'b1;
    end else begin
      // lead0 <= expb here, so the narrowing cast cannot lose bits.
      w_n_exp  = r_s3_expb - EXP_W'(w_lead0);
      w_n_frac = r_s3_sum[FRAC_W-1:0] << w_lead0;
    end
  end

  logic              r_out_valid;
  logic              r_sign_out;
  logic [EXP_W-1:0]  r_exp_out;
  logic [FRAC_W-1:0] r_frac_out;
  logic              r_ovf;
  logic              r_unf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_sign_out  <= 1'b0;
      r_exp_out   <= '0;
      r_frac_out  <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else if (!w_stall) begin
      r_out_valid <= r_s3_valid;
      r_sign_out  <= w_n_sign;
      r_exp_out   <= w_n_exp;
      r_frac_out  <= w_n_frac;
      // Flags are qualified so a bubble never shows ovf/unf.
      r_ovf       <= r_s3_valid & w_n_ovf;
      r_unf       <= r_s3_valid & w_n_unf;
    end
  end

  assign w_stall   = r_out_valid && !out_ready;
  assign in_ready  = !w_stall;

  assign out_valid = r_out_valid;
  assign sign_out  = r_sign_out;
  assign exp_out   = r_exp_out;
  assign frac_out  = r_frac_out;
  assign ovf       = r_ovf;
  assign unf       = r_unf;

endmodule

// File: tb/tb_fp_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp_adder_pipe
//
// Directed bench for fp_adder_pipe with default parameters (EXP_W=4,
// FRAC_W=8). Expected results are hand-computed constants packed as
// {sign, exp, frac, ovf, unf}.
// -----------------------------------------------------------------------------
module tb_fp_adder_pipe;

  localparam int EXP_W  = 4;
  localparam int FRAC_W = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic              op;
  logic              sign1;
  logic [EXP_W-1:0]  exp1;
  logic [FRAC_W-1:0] frac1;
  logic              sign2;
  logic [EXP_W-1:0]  exp2;
  logic [FRAC_W-1:0] frac2;
  logic              out_valid;
  logic              out_ready;
  logic              sign_out;
  logic [EXP_W-1:0]  exp_out;
  logic [FRAC_W-1:0] frac_out;
  logic              ovf;
  logic              unf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fp_adder_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .sign1    (sign1),
    .exp1     (exp1),
    .frac1    (frac1),
    .sign2    (sign2),
    .exp2     (exp2),
    .frac2    (frac2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sign_out (sign_out),
    .exp_out  (exp_out),
    .frac_out (frac_out),
    .ovf      (ovf),
    .unf      (unf)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          total = 0;
  int          bad   = 0;
  logic [14:0] exp_q[$];
  logic [26:0] vec[6];   // {op, sign1, exp1, frac1, sign2, exp2, frac2}
  logic [14:0] res[6];   // {sign, exp, frac, ovf, unf}

  function automatic logic [14:0] outs();
    return {sign_out, exp_out, frac_out, ovf, unf};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [26:0] v);
    {op, sign1, exp1, frac1, sign2, exp2, frac2} = v;
  endtask

  // One isolated operation: checks acceptance, exact 4-cycle latency, result.
  task automatic single(input string tag, input logic [26:0] v, input logic [14:0] expv);
    @(posedge clk); #1;
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c < 4) begin
        check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
      end else begin
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_result"}, 32'(outs()), 32'(expv));
      end
    end
  endtask

  // Watchdog: the directed sequence is a few hundred cycles long.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int          issue_idx;
    int          received;
    int          hold;
    int          stall_cycles;
    logic        first_seen;
    logic        have_snap;
    logic [14:0] snap;

    vec[0] = {1'b0, 1'b0, 4'h5, 8'h80, 1'b0, 4'h5, 8'h40};
    res[0] = {1'b0, 4'h5, 8'hC0, 1'b0, 1'b0};
    vec[1] = {1'b0, 1'b1, 4'h4, 8'hC0, 1'b1, 4'h2, 8'h80};
    res[1] = {1'b1, 4'h4, 8'hE0, 1'b0, 1'b0};
    vec[2] = {1'b1, 1'b0, 4'h3, 8'h90, 1'b0, 4'h6, 8'hA0};
    res[2] = {1'b1, 4'h6, 8'h8E, 1'b0, 1'b0};
    vec[3] = {1'b0, 1'b0, 4'hF, 8'hFF, 1'b0, 4'hF, 8'h01};
    res[3] = {1'b0, 4'hF, 8'hFF, 1'b1, 1'b0};
    vec[4] = {1'b0, 1'b0, 4'h2, 8'h10, 1'b1, 4'h0, 8'h08};
    res[4] = {1'b0, 4'h0, 8'h00, 1'b0, 1'b1};
    vec[5] = {1'b0, 1'b0, 4'hC, 8'h80, 1'b0, 4'h1, 8'hFF};
    res[5] = {1'b0, 4'hC, 8'h80, 1'b0, 1'b0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive('0);

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sign",      32'(sign_out),  32'd0);
    check("rst_exp",       32'(exp_out),   32'd0);
    check("rst_frac",      32'(frac_out),  32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    check("rst_unf",       32'(unf),       32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);

    // Directed single operations
    single("add_plain",  {1'b0, 1'b0, 4'h5, 8'h80, 1'b0, 4'h5, 8'h40}, {1'b0, 4'h5, 8'hC0, 1'b0, 1'b0});
    single("add_carry",  {1'b0, 1'b0, 4'h5, 8'h80, 1'b0, 4'h5, 8'h80}, {1'b0, 4'h6, 8'h80, 1'b0, 1'b0});
    single("sub_norm",   {1'b1, 1'b0, 4'h5, 8'h80, 1'b0, 4'h5, 8'h40}, {1'b0, 4'h4, 8'h80, 1'b0, 1'b0});
    single("overflow",   {1'b0, 1'b0, 4'hF, 8'hFF, 1'b0, 4'hF, 8'h01}, {1'b0, 4'hF, 8'hFF, 1'b1, 1'b0});
    single("cancel",     {1'b0, 1'b0, 4'h3, 8'hA0, 1'b1, 4'h3, 8'hA0}, {1'b0, 4'h0, 8'h00, 1'b0, 1'b0});
    single("underflow",  {1'b0, 1'b0, 4'h2, 8'h10, 1'b1, 4'h0, 8'h08}, {1'b0, 4'h0, 8'h00, 1'b0, 1'b1});
    single("align_big",  {1'b0, 1'b0, 4'hC, 8'h80, 1'b0, 4'h1, 8'hFF}, {1'b0, 4'hC, 8'h80, 1'b0, 1'b0});
    single("neg_add",    vec[1], res[1]);
    single("sub_swap",   vec[2], res[2]);

    // Backpressure: 6 back-to-back pairs, out_ready low 3 cycles after first result
    for (int k = 0; k < 6; k++) exp_q.push_back(res[k]);
    issue_idx    = 0;
    received     = 0;
    hold         = 0;
    stall_cycles = 0;
    first_seen   = 1'b0;
    have_snap    = 1'b0;
    snap         = '0;
    for (int cyc = 0; cyc < 60 && received < 6; cyc++) begin
      @(posedge clk); #1;
      if (issue_idx < 6) begin
        drive(vec[issue_idx]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (hold > 0) begin
        out_ready = 1'b0;
        hold--;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (in_valid && in_ready) issue_idx++;
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() > 0) check("bp_result", 32'(outs()), 32'(exp_q.pop_front()));
          else                  check("bp_extra_result", 32'(out_valid), 32'd0);
          received++;
          have_snap = 1'b0;
          if (!first_seen) begin
            first_seen = 1'b1;
            hold       = 3;
          end
        end else begin
          stall_cycles++;
          check("bp_stall_in_ready", 32'(in_ready), 32'd0);
          if (have_snap) begin
            check("bp_stable", 32'(outs()), 32'(snap));
          end else begin
            snap      = outs();
            have_snap = 1'b1;
          end
        end
      end
    end
    check("bp_received",     32'(received),     32'd6);
    check("bp_stall_cycles", 32'(stall_cycles), 32'd3);
    check("bp_queue_empty",  32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("bp_no_dup", 32'(out_valid), 32'd0);
    end

    // Reset mid-stream with 3 operations in flight
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      drive(vec[k]);
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    repeat (6) begin
      @(negedge clk);
      check("mid_rst_no_stale", 32'(out_valid), 32'd0);
    end
    single("post_rst", vec[1], res[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
